// File: rtl/mem_arbiter_if.sv
// Bus bundle between the icache/dcache miss FSMs, the memory arbiter and the main-memory port.
// slave = arbiter view; master = requesters plus memory view.
interface mem_arbiter_if #(
    parameter int AW    = 12,
    parameter int DW    = 128,
    parameter int BEATS = 4
);
    localparam int CW = $clog2(BEATS);

    logic          ic_req_valid;
    logic          ic_req_ready;
    logic [AW-1:0] ic_req_addr;
    logic          ic_rsp_valid;
    logic [DW-1:0] ic_rsp_data;
    logic          ic_done;

    logic          dc_req_valid;
    logic          dc_req_ready;
    logic [AW-1:0] dc_req_addr;
    logic          dc_req_rtype;
    logic [DW-1:0] dc_wdata;
    logic [CW-1:0] dc_wbeat;
    logic          dc_rsp_valid;
    logic [DW-1:0] dc_rsp_data;
    logic          dc_done;

    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_we;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;

    modport slave (
        input  ic_req_valid, ic_req_addr,
        input  dc_req_valid, dc_req_addr, dc_req_rtype, dc_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output ic_req_ready, ic_rsp_valid, ic_rsp_data, ic_done,
        output dc_req_ready, dc_wbeat, dc_rsp_valid, dc_rsp_data, dc_done,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
    );

    modport master (
        output ic_req_valid, ic_req_addr,
        output dc_req_valid, dc_req_addr, dc_req_rtype, dc_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  ic_req_ready, ic_rsp_valid, ic_rsp_data, ic_done,
        input  dc_req_ready, dc_wbeat, dc_rsp_valid, dc_rsp_data, dc_done,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the main-memory port between icache fills and dcache fills/evictions, one line burst per grant.
// Define MEM_ARB_DC_PRIO_EN for fixed dcache priority; default is round-robin.
module mem_arbiter #(
    parameter int AW    = 12,
    parameter int DW    = 128,
    parameter int BEATS = 4
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);
    localparam int CW = $clog2(BEATS);
    localparam logic [CW:0] LAST_BEAT = (CW+1)'(BEATS - 1);

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_RD   = 2'd1;
    localparam logic [1:0] ARB_WR   = 2'd2;

    localparam logic OWN_IC     = 1'b0;
    localparam logic OWN_DC     = 1'b1;
    localparam logic DMEM_WRITE = 1'b1;

    if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_beats_check
        $error("BEATS must be a power of 2 and at least 2");
    end

    logic [1:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic             rr_last_q, rr_last_d;
    logic [AW-CW-1:0] line_q, line_d;
    // One extra bit so "all BEATS done" is distinguishable from beat 0.
    logic [CW:0]      req_cnt_q, req_cnt_d;
    logic [CW:0]      rsp_cnt_q, rsp_cnt_d;
    logic             ic_rsp_valid_q, ic_rsp_valid_d, ic_done_q, ic_done_d;
    logic             dc_rsp_valid_q, dc_rsp_valid_d, dc_done_q, dc_done_d;
    logic [DW-1:0]    ic_rsp_data_q, ic_rsp_data_d, dc_rsp_data_q, dc_rsp_data_d;

    logic grant_ic, grant_dc, mem_valid, req_fire, rsp_expected, rsp_fire;

    // NOTE: every always_comb output is given a default first so no latch can be inferred.
    always_comb begin
        grant_ic = 1'b0;
        grant_dc = 1'b0;
        if (state_q == ARB_IDLE && !rst) begin
`ifdef MEM_ARB_DC_PRIO_EN
            grant_dc = bus.dc_req_valid;
            grant_ic = bus.ic_req_valid && !bus.dc_req_valid;
`else
            if (bus.ic_req_valid && bus.dc_req_valid) begin
                grant_ic = (rr_last_q == OWN_DC);
                grant_dc = !grant_ic;
            end else begin
                grant_ic = bus.ic_req_valid;
                grant_dc = bus.dc_req_valid;
            end
`endif
        end
    end

    assign mem_valid    = (state_q == ARB_RD || state_q == ARB_WR) && !req_cnt_q[CW];
    assign req_fire     = mem_valid && bus.mem_req_ready;
    assign rsp_expected = (state_q == ARB_RD) && !rsp_cnt_q[CW];
    assign rsp_fire     = rsp_expected && bus.mem_rsp_valid;

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        rr_last_d      = rr_last_q;
        line_d         = line_q;
        req_cnt_d      = req_cnt_q + {{CW{1'b0}}, req_fire};
        rsp_cnt_d      = rsp_cnt_q + {{CW{1'b0}}, rsp_fire};
        ic_rsp_valid_d = 1'b0;
        ic_done_d      = 1'b0;
        dc_rsp_valid_d = 1'b0;
        dc_done_d      = 1'b0;
        ic_rsp_data_d  = ic_rsp_data_q;
        dc_rsp_data_d  = dc_rsp_data_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_ic || grant_dc) begin
                    owner_d   = grant_dc ? OWN_DC : OWN_IC;
                    rr_last_d = owner_d;
                    line_d    = grant_dc ? bus.dc_req_addr[AW-1:CW] : bus.ic_req_addr[AW-1:CW];
                    req_cnt_d = '0;
                    rsp_cnt_d = '0;
                    state_d   = (grant_dc && bus.dc_req_rtype == DMEM_WRITE) ? ARB_WR : ARB_RD;
                end
            end
            ARB_RD: begin
                if (rsp_fire) begin
                    if (owner_q == OWN_DC) begin
                        dc_rsp_valid_d = 1'b1;
                        dc_rsp_data_d  = bus.mem_rsp_data;
                        dc_done_d      = (rsp_cnt_q == LAST_BEAT);
                    end else begin
                        ic_rsp_valid_d = 1'b1;
                        ic_rsp_data_d  = bus.mem_rsp_data;
                        ic_done_d      = (rsp_cnt_q == LAST_BEAT);
                    end
                end
                if (ic_done_q || dc_done_q) state_d = ARB_IDLE;
            end
            ARB_WR: begin
                dc_done_d = req_fire && (req_cnt_q == LAST_BEAT);
                if (dc_done_q) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ARB_IDLE;
            owner_q        <= OWN_IC;
            rr_last_q      <= OWN_DC;
            line_q         <= '0;
            req_cnt_q      <= '0;
            rsp_cnt_q      <= '0;
            ic_rsp_valid_q <= 1'b0;
            ic_done_q      <= 1'b0;
            dc_rsp_valid_q <= 1'b0;
            dc_done_q      <= 1'b0;
            ic_rsp_data_q  <= '0;
            dc_rsp_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            rr_last_q      <= rr_last_d;
            line_q         <= line_d;
            req_cnt_q      <= req_cnt_d;
            rsp_cnt_q      <= rsp_cnt_d;
            ic_rsp_valid_q <= ic_rsp_valid_d;
            ic_done_q      <= ic_done_d;
            dc_rsp_valid_q <= dc_rsp_valid_d;
            dc_done_q      <= dc_done_d;
            ic_rsp_data_q  <= ic_rsp_data_d;
            dc_rsp_data_q  <= dc_rsp_data_d;
        end
    end

    assign bus.ic_req_ready  = grant_ic;
    assign bus.dc_req_ready  = grant_dc;
    assign bus.ic_rsp_valid  = ic_rsp_valid_q;
    assign bus.ic_rsp_data   = ic_rsp_data_q;
    assign bus.ic_done       = ic_done_q;
    assign bus.dc_rsp_valid  = dc_rsp_valid_q;
    assign bus.dc_rsp_data   = dc_rsp_data_q;
    assign bus.dc_done       = dc_done_q;
    assign bus.dc_wbeat      = req_cnt_q[CW-1:0];
    assign bus.mem_req_valid = mem_valid;
    assign bus.mem_req_we    = (state_q == ARB_WR);
    assign bus.mem_req_addr  = {line_q, req_cnt_q[CW-1:0]};
    assign bus.mem_req_wdata = (state_q == ARB_WR) ? bus.dc_wdata : '0;

    a_ic_hold: assert property (@(posedge clk) disable iff (rst)
        bus.ic_req_valid && !bus.ic_req_ready |=> bus.ic_req_valid);
    a_dc_hold: assert property (@(posedge clk) disable iff (rst)
        bus.dc_req_valid && !bus.dc_req_ready |=> bus.dc_req_valid);
    a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
        bus.mem_rsp_valid |-> rsp_expected);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus burst sequences for reset and arbitration order.
module tb_mem_arbiter;
    localparam int AW = 12;
    localparam int DW = 128;
    localparam int BEATS = 4;

    typedef struct {
        logic        icv;  logic [11:0] ica;
        logic        dcv;  logic [11:0] dca;  logic dcw;
        logic        mrdy; logic mrv;  logic [7:0] mrd;
        logic        icr;  logic dcr;  logic mv;   logic we;
        logic [11:0] ma;   logic [1:0] wb;
        logic        icrv; logic icd;  logic [7:0] icdat;
        logic        dcrv; logic dcd;  logic [7:0] dcdat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if #(.AW(AW), .DW(DW), .BEATS(BEATS)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW), .BEATS(BEATS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Eviction data the dcache presents for whichever beat the arbiter asks for.
    assign bus.dc_wdata = {16{8'hD0 | 8'(bus.dc_wbeat)}};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic icv, input logic [11:0] ica, input logic dcv, input logic [11:0] dca,
        input logic dcw, input logic mrdy, input logic mrv, input logic [7:0] mrd,
        input logic icr, input logic dcr, input logic mv, input logic we,
        input logic [11:0] ma, input logic [1:0] wb,
        input logic icrv, input logic icd, input logic [7:0] icdat,
        input logic dcrv, input logic dcd, input logic [7:0] dcdat);
        vec_t v;
        v.icv = icv; v.ica = ica; v.dcv = dcv; v.dca = dca; v.dcw = dcw;
        v.mrdy = mrdy; v.mrv = mrv; v.mrd = mrd;
        v.icr = icr; v.dcr = dcr; v.mv = mv; v.we = we; v.ma = ma; v.wb = wb;
        v.icrv = icrv; v.icd = icd; v.icdat = icdat;
        v.dcrv = dcrv; v.dcd = dcd; v.dcdat = dcdat;
        return v;
    endfunction

    // Acts as memory for one granted burst: always ready, returns read beats one cycle after acceptance.
    task automatic serve_burst(input bit drop_ic, input bit drop_dc, output int n_rsp,
                               output int done_at, output logic [1:0] done_who,
                               output logic [11:0] first_addr, output bit timed_out);
        int pend = 0;
        int acc  = 0;
        n_rsp = 0; done_at = -1; done_who = 2'b00; first_addr = '0; timed_out = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 0 && drop_ic) bus.ic_req_valid = 1'b0;
            if (cyc == 0 && drop_dc) bus.dc_req_valid = 1'b0;
            bus.mem_req_ready = 1'b1;
            bus.mem_rsp_valid = (pend > 0);
            bus.mem_rsp_data  = {16{8'hC0 + 8'(n_rsp)}};
            if (pend > 0) pend--;
            @(negedge clk);
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                if (acc == 0) first_addr = bus.mem_req_addr;
                acc++;
                if (!bus.mem_req_we) pend++;
            end
            if (bus.ic_rsp_valid || bus.dc_rsp_valid) n_rsp++;
            if (bus.ic_done || bus.dc_done) begin
                done_at   = n_rsp;
                done_who  = {bus.dc_done, bus.ic_done};
                timed_out = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_req_ready = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        logic [21:0]  exp_ctrl, act_ctrl;
        int           n_rsp, done_at;
        logic [1:0]   done_who, exp_rdy, exp_done;
        logic [11:0]  first_addr;
        bit           timed_out;

        // icv ica   dcv dca   dcw rdy rv rd     icr dcr mv we ma    wb icrv icd icdat dcrv dcd dcdat
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 0,0,8'h00, 0,0,0,0,12'h000,0, 0,0,8'h00, 0,0,8'h00));
        vecs.push_back(mk(1,12'h013,0,12'h000,0, 0,0,8'h00, 1,0,0,0,12'h000,0, 0,0,8'h00, 0,0,8'h00));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 1,0,8'h00, 0,0,1,0,12'h010,0, 0,0,8'h00, 0,0,8'h00));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 1,1,8'hA0, 0,0,1,0,12'h011,0, 0,0,8'h00, 0,0,8'h00));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 1,0,8'h00, 0,0,1,0,12'h012,0, 1,0,8'hA0, 0,0,8'h00));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 1,1,8'hA1, 0,0,1,0,12'h013,0, 0,0,8'hA0, 0,0,8'h00));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 0,1,8'hA2, 0,0,0,0,12'h000,0, 1,0,8'hA1, 0,0,8'h00));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 0,1,8'hA3, 0,0,0,0,12'h000,0, 1,0,8'hA2, 0,0,8'h00));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 0,0,8'h00, 0,0,0,0,12'h000,0, 1,1,8'hA3, 0,0,8'h00));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 0,0,8'h00, 0,0,0,0,12'h000,0, 0,0,8'hA3, 0,0,8'h00));
        // Dirty-line eviction at 0x040 with memory ready toggling.
        vecs.push_back(mk(0,12'h000,1,12'h040,1, 0,0,8'h00, 0,1,0,0,12'h000,0, 0,0,8'hA3, 0,0,8'h00));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 1,0,8'h00, 0,0,1,1,12'h040,0, 0,0,8'hA3, 0,0,8'h00));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 0,0,8'h00, 0,0,1,1,12'h041,1, 0,0,8'hA3, 0,0,8'h00));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 1,0,8'h00, 0,0,1,1,12'h041,1, 0,0,8'hA3, 0,0,8'h00));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 0,0,8'h00, 0,0,1,1,12'h042,2, 0,0,8'hA3, 0,0,8'h00));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 1,0,8'h00, 0,0,1,1,12'h042,2, 0,0,8'hA3, 0,0,8'h00));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 0,0,8'h00, 0,0,1,1,12'h043,3, 0,0,8'hA3, 0,0,8'h00));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 1,0,8'h00, 0,0,1,1,12'h043,3, 0,0,8'hA3, 0,0,8'h00));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 0,0,8'h00, 0,0,0,1,12'h000,0, 0,0,8'hA3, 0,1,8'h00));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 0,0,8'h00, 0,0,0,0,12'h000,0, 0,0,8'hA3, 0,0,8'h00));
        // Dcache fill: first response lands on the 4th request handshake, then back-to-back.
        vecs.push_back(mk(0,12'h000,1,12'h7F5,0, 0,0,8'h00, 0,1,0,0,12'h000,0, 0,0,8'hA3, 0,0,8'h00));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 1,0,8'h00, 0,0,1,0,12'h7F4,0, 0,0,8'hA3, 0,0,8'h00));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 1,0,8'h00, 0,0,1,0,12'h7F5,0, 0,0,8'hA3, 0,0,8'h00));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 1,0,8'h00, 0,0,1,0,12'h7F6,0, 0,0,8'hA3, 0,0,8'h00));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 1,1,8'hB0, 0,0,1,0,12'h7F7,0, 0,0,8'hA3, 0,0,8'h00));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 0,1,8'hB1, 0,0,0,0,12'h000,0, 0,0,8'hA3, 1,0,8'hB0));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 0,1,8'hB2, 0,0,0,0,12'h000,0, 0,0,8'hA3, 1,0,8'hB1));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 0,1,8'hB3, 0,0,0,0,12'h000,0, 0,0,8'hA3, 1,0,8'hB2));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 0,0,8'h00, 0,0,0,0,12'h000,0, 0,0,8'hA3, 1,1,8'hB3));
        vecs.push_back(mk(0,12'h000,0,12'h000,0, 0,0,8'h00, 0,0,0,0,12'h000,0, 0,0,8'hA3, 0,0,8'hB3));

        rst = 1'b1;
        bus.ic_req_valid = 1'b0; bus.ic_req_addr = '0;
        bus.dc_req_valid = 1'b0; bus.dc_req_addr = '0; bus.dc_req_rtype = 1'b0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            bus.ic_req_valid  = vecs[i].icv;
            bus.ic_req_addr   = vecs[i].ica;
            bus.dc_req_valid  = vecs[i].dcv;
            bus.dc_req_addr   = vecs[i].dca;
            bus.dc_req_rtype  = vecs[i].dcw;
            bus.mem_req_ready = vecs[i].mrdy;
            bus.mem_rsp_valid = vecs[i].mrv;
            bus.mem_rsp_data  = {16{vecs[i].mrd}};
            @(negedge clk);
            exp_ctrl = {vecs[i].icr, vecs[i].dcr, vecs[i].mv, vecs[i].we,
                        vecs[i].mv ? vecs[i].ma : 12'h000, vecs[i].we ? vecs[i].wb : 2'b00,
                        vecs[i].icrv, vecs[i].icd, vecs[i].dcrv, vecs[i].dcd};
            act_ctrl = {bus.ic_req_ready, bus.dc_req_ready, bus.mem_req_valid, bus.mem_req_we,
                        vecs[i].mv ? bus.mem_req_addr : 12'h000, vecs[i].we ? bus.dc_wbeat : 2'b00,
                        bus.ic_rsp_valid, bus.ic_done, bus.dc_rsp_valid, bus.dc_done};
            check($sformatf("vec%0d ctrl", i), 128'(act_ctrl), 128'(exp_ctrl));
            check($sformatf("vec%0d ic_rsp_data", i), bus.ic_rsp_data, {16{vecs[i].icdat}});
            check($sformatf("vec%0d dc_rsp_data", i), bus.dc_rsp_data, {16{vecs[i].dcdat}});
            if (vecs[i].we)
                check($sformatf("vec%0d wdata", i), bus.mem_req_wdata, {16{8'hD0 | 8'(vecs[i].wb)}});
        end

        // Reset in the middle of an icache fill, after two responses.
        @(posedge clk); #1;
        bus.ic_req_valid = 1'b1; bus.ic_req_addr = 12'h100;
        @(negedge clk);
        check("rst_seq grant", 128'(bus.ic_req_ready), 128'(1));
        @(posedge clk); #1;
        bus.ic_req_valid = 1'b0; bus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = {16{8'hE0}};
        @(posedge clk); #1;
        bus.mem_rsp_data = {16{8'hE1}};
        @(negedge clk);
        check("rst_seq first beat", 128'(bus.ic_rsp_valid), 128'(1));
        @(posedge clk); #1;
        bus.mem_rsp_valid = 1'b0; bus.mem_req_ready = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_seq ctrl zero", 128'({bus.ic_req_ready, bus.dc_req_ready, bus.ic_rsp_valid, bus.ic_done,
                                         bus.dc_rsp_valid, bus.dc_done, bus.mem_req_valid, bus.mem_req_we,
                                         bus.mem_req_addr, bus.dc_wbeat}), 128'(0));
        check("rst_seq ic data zero", bus.ic_rsp_data, 128'(0));
        check("rst_seq dc data zero", bus.dc_rsp_data, 128'(0));
        check("rst_seq wdata zero", bus.mem_req_wdata, 128'(0));
        @(posedge clk); #1;
        bus.ic_req_valid = 1'b1; bus.ic_req_addr = 12'h203;
        @(negedge clk);
        check("rst_seq regrant", 128'(bus.ic_req_ready), 128'(1));
        serve_burst(1'b1, 1'b0, n_rsp, done_at, done_who, first_addr, timed_out);
        check("rst_seq timeout", 128'(timed_out), 128'(0));
        check("rst_seq first addr", 128'(first_addr), 128'(12'h200));
        check("rst_seq done beat", 128'(done_at), 128'(4));
        check("rst_seq done owner", 128'(done_who), 128'(2'b01));

        // Both requesters valid from reset: grant order over five bursts.
        rst = 1'b1;
        bus.ic_req_valid = 1'b1; bus.ic_req_addr = 12'h080;
        bus.dc_req_valid = 1'b1; bus.dc_req_addr = 12'h0C0; bus.dc_req_rtype = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int b = 0; b < 5; b++) begin
`ifdef MEM_ARB_DC_PRIO_EN
            exp_rdy = (b < 4) ? 2'b01 : 2'b10;
`else
            exp_rdy = (b % 2 == 0) ? 2'b10 : 2'b01;
`endif
            exp_done = {exp_rdy[0], exp_rdy[1]};
            @(negedge clk);
            check($sformatf("arb%0d ready", b), 128'({bus.ic_req_ready, bus.dc_req_ready}), 128'(exp_rdy));
            serve_burst(b == 4, b == 3, n_rsp, done_at, done_who, first_addr, timed_out);
            check($sformatf("arb%0d timeout", b), 128'(timed_out), 128'(0));
            check($sformatf("arb%0d done owner", b), 128'(done_who), 128'(exp_done));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
